program_loader: RTL
===================

Name: program_loader

Overview:
- Write-side companion to the instruction ROM. Accepts a byte stream over a valid/ready handshake and packs it big-endian into 32-bit words.
- Writes each word into the program memory's load port at consecutive word-aligned byte addresses.
- Holds the MIPS core in reset while loading. Flags completion or a rejected request.

Parameters:
- MEMORY_DEPTH, 32, number of words in the program memory; upper bound on load length.
- DATA_WIDTH, 32, instruction/word width and address width.
- BASE_ADDRESS, 32'h0000_0000, byte address of the first written word. Must be 4-byte aligned.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start_i  input  1  one-cycle load request; sampled only in IDLE.
- length_i  input  LEN_W=$clog2(MEMORY_DEPTH+1)  number of words to load; sampled with start_i.
- byte_data_i  input  8  stream byte.
- byte_valid_i  input  1  byte_data_i is valid.
- byte_ready_o  output  1  loader can accept a byte.
- write_enable_o  output  1  one-cycle memory write strobe.
- write_address_o  output  DATA_WIDTH  byte address of the write. Memory indexes by address[DATA_WIDTH-1:2].
- write_data_o  output  DATA_WIDTH  assembled instruction word.
- cpu_hold_o  output  1  high while loading; drives the core reset.
- busy_o  output  1  high in any state other than IDLE.
- done_o  output  1  one-cycle pulse when the last word has been written.
- error_o  output  1  one-cycle pulse when a start request is rejected.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - Word index, byte count and shift register go to 0.
  - All outputs go to 0.
  - A partial word or partial load is discarded; nothing is written.
- States: IDLE, RECEIVE, WRITE, DONE.
- IDLE:
  - start_i=1 with 1 <= length_i <= MEMORY_DEPTH: latch length_i, clear word index and byte count, go to RECEIVE.
  - start_i=1 with length_i=0 or length_i>MEMORY_DEPTH: error_o=1 next cycle for one cycle; stay IDLE; no writes.
- start_i is ignored in every state except IDLE.
- RECEIVE:
  - byte_ready_o=1.
  - A byte is accepted on a cycle where byte_valid_i && byte_ready_o.
  - Accepted bytes shift in MSB-first: the first byte lands in [31:24], the fourth in [7:0].
  - After the 4th accepted byte, go to WRITE.
  - byte_valid_i low stalls indefinitely, with no timeout.
- WRITE (exactly one cycle):
  - byte_ready_o=0; write_enable_o=1.
  - write_address_o = BASE_ADDRESS + 4*word_index; write_data_o = assembled word.
  - Increment word index and clear byte count.
  - If the incremented index equals the latched length, go to DONE; otherwise go to RECEIVE.
- DONE (one cycle): done_o=1, then IDLE.
- Outside WRITE, write_enable_o=0. write_address_o and write_data_o hold their last values and are don't-care.
- cpu_hold_o = 1 in RECEIVE, WRITE and DONE; deasserts the cycle the FSM returns to IDLE.
- Throughput: 5 cycles per word minimum (4 accept cycles + 1 write cycle).
- Latency: the 4th byte accepted at edge N gives write_enable_o high in cycle N+1.
- Address arithmetic:
  - Computed in DATA_WIDTH bits and wraps modulo 2^DATA_WIDTH.
  - The word index never exceeds MEMORY_DEPTH-1 because the length check bounds it.
- Outputs are registered or decoded from state only; no combinational path from inputs to outputs.

Decomposition:
- Shared package loader_pkg:
  - state enum (IDLE, RECEIVE, WRITE, DONE);
  - BYTES_PER_WORD=4;
  - byte-count width of 2.
- Sub-module word_assembler:
  - byte shift register plus 2-bit byte counter;
  - inputs: clk, reset, clear, shift_en, byte;
  - outputs: word, word_complete.
- The top level holds the FSM, length latch, word index and address generation.

Test Plan:
- Reset assert/deassert with no stimulus -> every output is 0; byte_ready_o=0; cpu_hold_o=0.
- start_i with length_i=1, bytes 20,08,00,05 back-to-back -> single write_enable_o pulse with addr 0, data 32'h2008_0005; done_o pulses the cycle after; cpu_hold_o high from the cycle after start until IDLE.
- length_i=3, 12 bytes with random 0-3 cycle valid gaps -> exactly 3 writes at addresses 0, 4, 8 with correctly packed data; byte_ready_o=0 during each WRITE cycle; no byte is lost or duplicated.
- length_i=0, then length_i=33 -> error_o one-cycle pulse each time; busy_o stays 0; no writes. Then length_i=32 -> 32 writes, last at addr 0x7C.
- Reset asserted after 2 bytes of word 1 -> outputs clear immediately, no write. A new start with length 1 and bytes AA,BB,CC,DD -> writes 32'hAABB_CCDD at addr 0.
- start_i pulsed during RECEIVE -> ignored; the load completes with the original length.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM encoding and byte/word geometry.
package loader_pkg;

  // Bytes packed into one program word, and the counter width that walks them.
  localparam int BYTES_PER_WORD = 4;
  localparam int BCNT_W         = 2;
  localparam int WORD_W         = 8 * BYTES_PER_WORD;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECEIVE = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/word_assembler.sv
// Big-endian byte packer: first accepted byte ends up in the MSB of the word.
// The completed word is loaded into a holding register on the last byte, so
// it stays stable through the write cycle and afterwards until the next word.
module word_assembler
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_complete
);

  logic [WORD_W-9:0] part;
  logic [BCNT_W-1:0] cnt;

  // The byte being shifted in this cycle is the last one of the word.
  assign word_complete = shift_en && (cnt == BCNT_W'(BYTES_PER_WORD - 1));

  // Partial-word shift register, byte counter and completed-word register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      part <= '0;
      cnt  <= '0;
      word <= '0;
    end else if (clear) begin
      part <= '0;
      cnt  <= '0;
    end else if (shift_en) begin
      cnt <= cnt + 1'b1;
      if (word_complete) begin
        word <= {part, byte_in};
        part <= '0;
      end else begin
        part <= {part[WORD_W-17:0], byte_in};
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// Program loader: receives a byte stream, packs it into 32-bit words and
// writes them to the program memory load port while holding the core in reset.
module program_loader
  import loader_pkg::*;
#(
  parameter int                    MEMORY_DEPTH = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = '0,
  localparam int                   LEN_W        = $clog2(MEMORY_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [LEN_W-1:0]      length_i,
  input  logic [7:0]            byte_data_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  output logic                  write_enable_o,
  output logic [DATA_WIDTH-1:0] write_address_o,
  output logic [DATA_WIDTH-1:0] write_data_o,
  output logic                  cpu_hold_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o
);

  localparam logic [1:0] IDLE    = ST_IDLE;
  localparam logic [1:0] RECEIVE = ST_RECEIVE;
  localparam logic [1:0] WRITE   = ST_WRITE;
  localparam logic [1:0] DONE    = ST_DONE;

  logic [1:0]            state;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      idx;
  logic [LEN_W-1:0]      idx_nxt;
  logic                  len_ok;
  logic                  accept;
  logic                  asm_clear;
  logic                  asm_complete;
  logic [DATA_WIDTH-1:0] asm_word;
  logic [DATA_WIDTH-1:0] addr_off;

  // A load must cover at least one word and fit in the memory.
  assign len_ok   = (length_i != '0) && (length_i <= LEN_W'(MEMORY_DEPTH));
  assign accept   = (state == RECEIVE) && byte_valid_i;
  assign idx_nxt  = idx + 1'b1;
  assign addr_off = DATA_WIDTH'({idx, 2'b00});

  // Byte counter restarts on every accepted load and after every write.
  assign asm_clear = ((state == IDLE) && start_i && len_ok) || (state == WRITE);

  word_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .clear        (asm_clear),
    .shift_en     (accept),
    .byte_in      (byte_data_i),
    .word         (asm_word),
    .word_complete(asm_complete)
  );

  // Control outputs decode straight from the state register.
  assign byte_ready_o   = (state == RECEIVE);
  assign write_enable_o = (state == WRITE);
  assign done_o         = (state == DONE);
  assign busy_o         = (state != IDLE);
  assign cpu_hold_o     = (state != IDLE);
  assign write_data_o   = asm_word;

  // FSM, length latch, word index, write address and reject pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      len_q           <= '0;
      idx             <= '0;
      write_address_o <= '0;
      error_o         <= 1'b0;
    end else begin
      error_o <= (state == IDLE) && start_i && !len_ok;
      case (state)
        IDLE: begin
          if (start_i && len_ok) begin
            len_q <= length_i;
            idx   <= '0;
            state <= RECEIVE;
          end
        end
        RECEIVE: begin
          // Address is captured with the last byte so it is valid in WRITE.
          if (asm_complete) begin
            write_address_o <= BASE_ADDRESS + addr_off;
            state           <= WRITE;
          end
        end
        WRITE: begin
          idx   <= idx_nxt;
          state <= (idx_nxt == len_q) ? DONE : RECEIVE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
